pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/pipeline_ctrl_scoreboard.sv | 57 +++++
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forwarding selects and FSM states.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    FLUSH
  } pipe_state_e;

  localparam int FLUSH_CNT_W = 3;
  localparam int PERF_W      = 32;

  // EX-stage producer is the younger one, so it wins over the MEM-stage producer.
  function automatic fwd_sel_e fwdSelect(input logic exHit, input logic memHit);
    if (exHit)       return FWD_MEM;
    else if (memHit) return FWD_WB;
    else             return FWD_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// Destination-register tracking for EX/MEM plus load-use and forwarding match logic.
module pipe_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  input  logic              i_bubble,
  input  logic              i_id_valid,
  input  logic [NREG_W-1:0] i_rs1,
  input  logic [NREG_W-1:0] i_rs2,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic [NREG_W-1:0] i_rd,
  input  logic              i_mem_re,
  output logic              o_lu_hz,
  output fwd_sel_e          o_fwd1_sel,
  output fwd_sel_e          o_fwd2_sel
);

  logic              r_exVld;
  logic [NREG_W-1:0] r_exRd;
  logic              r_exLd;
  logic              r_memVld;
  logic [NREG_W-1:0] r_memRd;

  logic w_rs1Ex, w_rs2Ex, w_rs1Mem, w_rs2Mem;

  // x0 is never a producer, so an instruction writing rd=0 enters EX as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exVld  <= 1'b0;
      r_exRd   <= '0;
      r_exLd   <= 1'b0;
      r_memVld <= 1'b0;
      r_memRd  <= '0;
    end else if (i_advance) begin
      r_exVld  <= i_id_valid & ~i_bubble & (i_rd != '0);
      r_exRd   <= i_rd;
      r_exLd   <= i_mem_re;
      r_memVld <= r_exVld;
      r_memRd  <= r_exRd;
    end
  end

  assign w_rs1Ex  = i_rs1_used & (i_rs1 != '0) & r_exVld  & (i_rs1 == r_exRd);
  assign w_rs2Ex  = i_rs2_used & (i_rs2 != '0) & r_exVld  & (i_rs2 == r_exRd);
  assign w_rs1Mem = i_rs1_used & (i_rs1 != '0) & r_memVld & (i_rs1 == r_memRd);
  assign w_rs2Mem = i_rs2_used & (i_rs2 != '0) & r_memVld & (i_rs2 == r_memRd);

  assign o_lu_hz    = i_id_valid & r_exLd & (w_rs1Ex | w_rs2Ex);
  assign o_fwd1_sel = fwdSelect(w_rs1Ex, w_rs1Mem);
  assign o_fwd2_sel = fwdSelect(w_rs2Ex, w_rs2Mem);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stall, bubble, flush and registered EX forwarding selects.
// Optional perf counters are built only when PIPE_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int NREG_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [NREG_W-1:0] id_rs1_i,
  input  logic [NREG_W-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [NREG_W-1:0] id_rd_i,
  input  logic              id_mem_re_i,
  input  logic              ex_redirect_i,
  input  logic              mem_busy_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              bubble_ex_o,
  output logic              flush_o,
  output fwd_sel_e          fwd_rs1_o,
  output fwd_sel_e          fwd_rs2_o,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o
);

  pipe_state_e            r_state;
  logic [FLUSH_CNT_W-1:0] r_flushCnt;
  fwd_sel_e               r_fwd1;
  fwd_sel_e               r_fwd2;

  pipe_state_e            w_nextState;
  logic [FLUSH_CNT_W-1:0] w_nextCnt;
  logic                   w_stall, w_bubble, w_flush, w_luHz;
  fwd_sel_e               w_fwd1Sel, w_fwd2Sel;

  pipe_scoreboard #(.NREG_W(NREG_W)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_advance  (~mem_busy_i),
    .i_bubble   (w_bubble),
    .i_id_valid (id_valid_i),
    .i_rs1      (id_rs1_i),
    .i_rs2      (id_rs2_i),
    .i_rs1_used (id_rs1_used_i),
    .i_rs2_used (id_rs2_used_i),
    .i_rd       (id_rd_i),
    .i_mem_re   (id_mem_re_i),
    .o_lu_hz    (w_luHz),
    .o_fwd1_sel (w_fwd1Sel),
    .o_fwd2_sel (w_fwd2Sel)
  );

  // A memory freeze overrides everything; a redirect in FLUSH is ignored because EX holds a bubble.
  always_comb begin
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_nextState = r_state;
    w_nextCnt   = r_flushCnt;
    if (mem_busy_i) begin
      w_stall = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_redirect_i) begin
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_nextCnt   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            w_nextState = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (w_luHz) begin
            w_stall     = 1'b1;
            w_bubble    = 1'b1;
            w_nextState = LU_STALL;
          end
        end
        LU_STALL: w_nextState = RUN;
        FLUSH: begin
          w_flush   = 1'b1;
          w_bubble  = 1'b1;
          w_nextCnt = r_flushCnt - 1'b1;
          if (r_flushCnt == FLUSH_CNT_W'(1)) w_nextState = RUN;
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_flushCnt <= '0;
      r_fwd1     <= FWD_NONE;
      r_fwd2     <= FWD_NONE;
    end else if (!mem_busy_i) begin
      r_state    <= w_nextState;
      r_flushCnt <= w_nextCnt;
      if (w_bubble || !id_valid_i) begin
        r_fwd1 <= FWD_NONE;
        r_fwd2 <= FWD_NONE;
      end else begin
        r_fwd1 <= w_fwd1Sel;
        r_fwd2 <= w_fwd2Sel;
      end
    end
  end

  assign stall_if_o  = w_stall;
  assign stall_id_o  = w_stall;
  assign bubble_ex_o = w_bubble;
  assign flush_o     = w_flush;
  assign fwd_rs1_o   = r_fwd1;
  assign fwd_rs2_o   = r_fwd2;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] r_perfStall;
  logic [PERF_W-1:0] r_perfFlush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perfStall <= '0;
      r_perfFlush <= '0;
    end else begin
      if (w_stall && (r_perfStall != '1)) r_perfStall <= r_perfStall + 1'b1;
      if (w_flush && (r_perfFlush != '1)) r_perfFlush <= r_perfFlush + 1'b1;
    end
  end

  assign perf_stall_cnt_o = r_perfStall;
  assign perf_flush_cnt_o = r_perfFlush;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expected outputs queued with stimulus, popped at negedge.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  typedef struct packed {
    logic     stall;
    logic     bubble;
    logic     flush;
    fwd_sel_e fwd1;
    fwd_sel_e fwd2;
  } expect_t;

  logic        clk;
  logic        rst_n;
  logic        idValid;
  logic [4:0]  idRs1, idRs2, idRd;
  logic        idRs1Used, idRs2Used, idMemRe;
  logic        exRedirect, memBusy;
  logic        stallIf, stallId, bubbleEx, flush;
  fwd_sel_e    fwdRs1, fwdRs2;
  logic [31:0] perfStall, perfFlush;

  expect_t     expQ[$];
  int          total = 0;
  int          bad = 0;
  int          expStallCnt = 0;
  int          expFlushCnt = 0;

  pipeline_ctrl #(.FLUSH_CYCLES(2), .NREG_W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid_i       (idValid),
    .id_rs1_i         (idRs1),
    .id_rs2_i         (idRs2),
    .id_rs1_used_i    (idRs1Used),
    .id_rs2_used_i    (idRs2Used),
    .id_rd_i          (idRd),
    .id_mem_re_i      (idMemRe),
    .ex_redirect_i    (exRedirect),
    .mem_busy_i       (memBusy),
    .stall_if_o       (stallIf),
    .stall_id_o       (stallId),
    .bubble_ex_o      (bubbleEx),
    .flush_o          (flush),
    .fwd_rs1_o        (fwdRs1),
    .fwd_rs2_o        (fwdRs2),
    .perf_stall_cnt_o (perfStall),
    .perf_flush_cnt_o (perfFlush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of ID/EX/MEM inputs just after the edge and queue what that cycle must show.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic re, input logic redir, input logic busy,
                               input logic eSt, input logic eBub, input logic eFl,
                               input fwd_sel_e e1, input fwd_sel_e e2);
    expect_t e;
    @(posedge clk);
    #1;
    idValid = v; idRs1 = rs1; idRs2 = rs2; idRs1Used = u1; idRs2Used = u2;
    idRd = rd; idMemRe = re; exRedirect = redir; memBusy = busy;
    e.stall = eSt; e.bubble = eBub; e.flush = eFl; e.fwd1 = e1; e.fwd2 = e2;
    expQ.push_back(e);
    if (eSt) expStallCnt++;
    if (eFl) expFlushCnt++;
  endtask

  task automatic compareCycle(input string tag);
    expect_t e;
    @(negedge clk);
    e = expQ.pop_front();
    checkOutput({tag, ".stallIf"}, 32'(stallIf), 32'(e.stall));
    checkOutput({tag, ".stallId"}, 32'(stallId), 32'(e.stall));
    checkOutput({tag, ".bubble"}, 32'(bubbleEx), 32'(e.bubble));
    checkOutput({tag, ".flush"}, 32'(flush), 32'(e.flush));
    checkOutput({tag, ".fwd1"}, 32'(fwdRs1), 32'(e.fwd1));
    checkOutput({tag, ".fwd2"}, 32'(fwdRs2), 32'(e.fwd2));
  endtask

  task automatic runStep(input string tag, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic re, input logic redir, input logic busy,
                         input logic eSt, input logic eBub, input logic eFl,
                         input fwd_sel_e e1, input fwd_sel_e e2);
    applyStimulus(v, rs1, rs2, u1, u2, rd, re, redir, busy, eSt, eBub, eFl, e1, e2);
    compareCycle(tag);
  endtask

  task automatic idle(input string tag, input fwd_sel_e e1, input fwd_sel_e e2);
    runStep(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e1, e2);
  endtask

  initial begin
    rst_n = 1'b0;
    idValid = 0; idRs1 = 0; idRs2 = 0; idRs1Used = 0; idRs2Used = 0;
    idRd = 0; idMemRe = 0; exRedirect = 0; memBusy = 0;
    #12;
    checkOutput("rst.stallIf", 32'(stallIf), 0);
    checkOutput("rst.stallId", 32'(stallId), 0);
    checkOutput("rst.bubble", 32'(bubbleEx), 0);
    checkOutput("rst.flush", 32'(flush), 0);
    checkOutput("rst.fwd1", 32'(fwdRs1), 32'(FWD_NONE));
    checkOutput("rst.fwd2", 32'(fwdRs2), 32'(FWD_NONE));
    checkOutput("rst.perfStall", perfStall, 0);
    #5 rst_n = 1'b1;

    // Load-use: LW x5 ; ADD x6,x5,x1
    runStep("lw5",    1, 1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    runStep("luStall",1, 5, 1, 1, 1, 6, 0, 0, 0, 1, 1, 0, FWD_NONE, FWD_NONE);
    runStep("luRel",  1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    // ADD now in EX with rs1 from WB; ADDI x3,x0 in ID
    runStep("addiX3", 1, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, FWD_WB,   FWD_NONE);
    runStep("subX4",  1, 3, 3, 1, 1, 4, 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    idle("subInEx", FWD_MEM, FWD_MEM);
    // Double match: ADDI x7 ; ADDI x7,x7 ; ADD x8,x7,x0 -> EX producer wins
    runStep("addiX7a",1, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    runStep("addiX7b",1, 7, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    runStep("addX8",  1, 7, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, FWD_MEM,  FWD_NONE);
    idle("addX8InEx", FWD_MEM, FWD_NONE);
    // Redirect; a second redirect during FLUSH must not extend it
    runStep("redir",  1, 1, 2, 1, 1, 9, 0, 1, 0, 0, 1, 1, FWD_NONE, FWD_NONE);
    runStep("flush2", 1, 1, 2, 1, 1, 9, 0, 1, 0, 0, 1, 1, FWD_NONE, FWD_NONE);
    idle("flushEnd", FWD_NONE, FWD_NONE);
    // Load-use with memory freeze held three cycles
    runStep("lw10",   1, 1, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    runStep("busy1",  1, 2, 10, 1, 1, 11, 0, 0, 1, 1, 0, 0, FWD_NONE, FWD_NONE);
    runStep("busy2",  1, 2, 10, 1, 1, 11, 0, 0, 1, 1, 0, 0, FWD_NONE, FWD_NONE);
    runStep("busy3",  1, 2, 10, 1, 1, 11, 0, 0, 1, 1, 0, 0, FWD_NONE, FWD_NONE);
    runStep("luAfterBusy", 1, 2, 10, 1, 1, 11, 0, 0, 0, 1, 1, 0, FWD_NONE, FWD_NONE);
    runStep("luRel2", 1, 2, 10, 1, 1, 11, 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    idle("orInEx", FWD_NONE, FWD_WB);
    // LW x0 then ADD x12,x0,x0: no hazard, no forwarding
    runStep("lwX0",   1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    runStep("useX0",  1, 0, 0, 1, 1, 12, 0, 0, 0, 0, 0, 0, FWD_NONE, FWD_NONE);
    idle("useX0InEx", FWD_NONE, FWD_NONE);
    // Freeze in the middle of a flush holds the flush counter
    runStep("redir2", 1, 1, 2, 1, 1, 9, 0, 1, 0, 0, 1, 1, FWD_NONE, FWD_NONE);
    runStep("flushBusy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FWD_NONE, FWD_NONE);
    runStep("flushResume", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FWD_NONE, FWD_NONE);
    idle("flushDone", FWD_NONE, FWD_NONE);

`ifdef PIPE_PERF_EN
    checkOutput("perfStall", perfStall, 32'(expStallCnt));
    checkOutput("perfFlush", perfFlush, 32'(expFlushCnt));
`else
    checkOutput("perfStallOff", perfStall, 0);
    checkOutput("perfFlushOff", perfFlush, 0);
`endif

    // Asynchronous reset in the middle of a flush
    runStep("redir3", 1, 1, 2, 1, 1, 9, 0, 1, 0, 0, 1, 1, FWD_NONE, FWD_NONE);
    @(posedge clk);
    #1;
    idValid = 0; exRedirect = 0;
    #1;
    checkOutput("preRst.flush", 32'(flush), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst.flush", 32'(flush), 0);
    checkOutput("asyncRst.bubble", 32'(bubbleEx), 0);
    checkOutput("asyncRst.stall", 32'(stallId), 0);
    checkOutput("asyncRst.perfStall", perfStall, 0);
    checkOutput("asyncRst.perfFlush", perfFlush, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle("postRst", FWD_NONE, FWD_NONE);

    checkOutput("queueDrained", 32'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
